fft_peak_pick: RTL and testbench

- Streaming stage directly downstream of the fft operator. Consumes one complex frequency-domain frame per packet (sop/eop/valid framed).
- Computes squared magnitude per bin over the non-mirrored half-spectrum and tracks the strongest bin.
- At frame end, emits one result beat: bin index, raw re/im at that bin, and its magnitude. The phase stage downstream uses these values for phase computation.

---
 rtl/fft_peak_pick.sv | 168 ++++++++++++++++
 tb/tb_fft_peak_pick.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_pick.sv
// Purpose: squared-magnitude peak search over the lower half of one FFT frame per packet.
// Latency: result strobe 3 clk after the accepted eop sample.
// Backpressure: none; the sink is never stalled and results are single-cycle strobes.
`timescale 1ns/1ps
module fft_peak_pick #(
    parameter int FFT_DEPTH = 11,
    parameter int FFT_WIDTH = 20,
    parameter bit SKIP_DC   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sink_sop,
    input  logic                          sink_eop,
    input  logic                          sink_valid,
    input  logic signed [FFT_WIDTH-1:0]   sink_re,
    input  logic signed [FFT_WIDTH-1:0]   sink_im,
    output logic                          source_valid,
    output logic        [FFT_DEPTH-2:0]   source_bin,
    output logic signed [FFT_WIDTH-1:0]   source_re,
    output logic signed [FFT_WIDTH-1:0]   source_im,
    output logic        [2*FFT_WIDTH-1:0] source_mag,
    output logic                          busy,
    output logic                          error
);
    localparam int MW = 2 * FFT_WIDTH;
    localparam int BW = FFT_DEPTH - 1;
    localparam logic [BW-1:0] INIT_BIN = BW'(SKIP_DC);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [FFT_DEPTH-1:0]   cnt, cnt_nxt, in_bin;
    logic                   take, first, last, err_nxt, error_q;

    logic                   s1_vld, s1_first, s1_last, s1_cand;
    logic [BW-1:0]          s1_bin;
    logic signed [FFT_WIDTH-1:0] s1_re, s1_im;

    logic                   s2_vld, s2_first, s2_last, s2_cand;
    logic [BW-1:0]          s2_bin;
    logic signed [FFT_WIDTH-1:0] s2_re, s2_im;
    logic signed [MW-1:0]   s2_rr, s2_ii;

    logic [BW-1:0]          pk_bin, base_bin, nx_bin;
    logic signed [FFT_WIDTH-1:0] pk_re, pk_im, base_re, base_im, nx_re, nx_im;
    logic [MW-1:0]          pk_mag, base_mag, nx_mag, mag;

    // Intake FSM; a sop is always taken as a fresh frame start, whatever the state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        err_nxt   = 1'b0;
        if (state == DRAIN && s2_vld && s2_last)
            state_nxt = IDLE;
        if (sink_valid) begin
            if (sink_sop) begin
                err_nxt   = (state == COLLECT);
                take      = 1'b1;
                first     = 1'b1;
                cnt_nxt   = FFT_DEPTH'(1);
                state_nxt = COLLECT;
            end else if (state != COLLECT) begin
                err_nxt = 1'b1;
            end else if (sink_eop) begin
                if (cnt == '1) begin
                    take      = 1'b1;
                    last      = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end else if (cnt == '1) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
            end else begin
                take    = 1'b1;
                cnt_nxt = cnt + FFT_DEPTH'(1);
            end
        end
    end

    assign in_bin = first ? '0 : cnt;
    assign busy   = (state != IDLE);
    assign error  = error_q & ~reset;

    // Final stage: the first sample of a frame compares against a cleared peak, not the old one.
    always_comb begin
        mag      = $unsigned(s2_rr) + $unsigned(s2_ii);
        base_bin = s2_first ? INIT_BIN : pk_bin;
        base_re  = s2_first ? '0 : pk_re;
        base_im  = s2_first ? '0 : pk_im;
        base_mag = s2_first ? '0 : pk_mag;
        nx_bin   = base_bin;
        nx_re    = base_re;
        nx_im    = base_im;
        nx_mag   = base_mag;
        if (s2_cand && mag > base_mag) begin
            nx_bin = s2_bin;
            nx_re  = s2_re;
            nx_im  = s2_im;
            nx_mag = mag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            error_q      <= 1'b0;
            s1_vld       <= 1'b0;
            s2_vld       <= 1'b0;
            source_valid <= 1'b0;
            source_bin   <= '0;
            source_re    <= '0;
            source_im    <= '0;
            source_mag   <= '0;
            pk_bin       <= '0;
            pk_re        <= '0;
            pk_im        <= '0;
            pk_mag       <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            error_q      <= err_nxt;
            s1_vld       <= take;
            s2_vld       <= s1_vld;
            source_valid <= s2_vld && s2_last;
            if (s2_vld) begin
                pk_bin <= nx_bin;
                pk_re  <= nx_re;
                pk_im  <= nx_im;
                pk_mag <= nx_mag;
                if (s2_last) begin
                    source_bin <= nx_bin;
                    source_re  <= nx_re;
                    source_im  <= nx_im;
                    source_mag <= nx_mag;
                end
            end
        end
    end

    // Datapath registers carry no reset; only the valids qualify them.
    always_ff @(posedge clk) begin
        if (take) begin
            s1_first <= first;
            s1_last  <= last;
            s1_cand  <= !in_bin[FFT_DEPTH-1] && !(SKIP_DC && in_bin == '0);
            s1_bin   <= in_bin[BW-1:0];
            s1_re    <= sink_re;
            s1_im    <= sink_im;
        end
        if (s1_vld) begin
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_cand  <= s1_cand;
            s2_bin   <= s1_bin;
            s2_re    <= s1_re;
            s2_im    <= s1_im;
            s2_rr    <= MW'(s1_re) * MW'(s1_re);
            s2_ii    <= MW'(s1_im) * MW'(s1_im);
        end
    end
endmodule

// File: tb/tb_fft_peak_pick.sv
// Bench for fft_peak_pick: two instances (SKIP_DC=1 and 0) share one stimulus stream;
// expected peaks are queued at eop and compared when each result strobe appears.
`timescale 1ns/1ps
module tb_fft_peak_pick;
    localparam int D = 3;
    localparam int W = 8;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sop = 1'b0, eop = 1'b0, vld = 1'b0;
    logic signed [W-1:0] re = '0, im = '0;

    logic sv1, busy1, err1, sv0, busy0, err0;
    logic [D-2:0] bin1, bin0;
    logic signed [W-1:0] re1, im1, re0, im0;
    logic [2*W-1:0] mag1, mag0;

    fft_peak_pick #(.FFT_DEPTH(D), .FFT_WIDTH(W), .SKIP_DC(1'b1)) dut1 (
        .clk(clk), .reset(reset), .sink_sop(sop), .sink_eop(eop), .sink_valid(vld),
        .sink_re(re), .sink_im(im), .source_valid(sv1), .source_bin(bin1),
        .source_re(re1), .source_im(im1), .source_mag(mag1), .busy(busy1), .error(err1));

    fft_peak_pick #(.FFT_DEPTH(D), .FFT_WIDTH(W), .SKIP_DC(1'b0)) dut0 (
        .clk(clk), .reset(reset), .sink_sop(sop), .sink_eop(eop), .sink_valid(vld),
        .sink_re(re), .sink_im(im), .source_valid(sv0), .source_bin(bin0),
        .source_re(re0), .source_im(im0), .source_mag(mag0), .busy(busy0), .error(err0));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [D-2:0]        bin;
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        logic [2*W-1:0]      mag;
        int                  cyc;
    } exp_t;

    exp_t q1[$], q0[$];
    exp_t e1m, e0m;
    int res_t1[$];
    int checks = 0, errors = 0;
    int n_res1 = 0, n_res0 = 0, n_exp = 0;
    int err_cnt1 = 0, err_cnt0 = 0, exp_err = 0;
    logic signed [W-1:0] fr_re[N], fr_im[N];

    task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference peak search straight from the bin definition.
    function automatic exp_t model(input bit skip);
        exp_t e;
        int m;
        e.bin = skip ? 2'd1 : 2'd0;
        e.re  = '0;
        e.im  = '0;
        e.mag = '0;
        e.cyc = 0;
        for (int b = 0; b < N / 2; b++) begin
            if (skip && b == 0) continue;
            m = int'(fr_re[b]) * int'(fr_re[b]) + int'(fr_im[b]) * int'(fr_im[b]);
            if (m > int'(e.mag)) begin
                e.bin = b[D-2:0];
                e.re  = fr_re[b];
                e.im  = fr_im[b];
                e.mag = m[2*W-1:0];
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic e, input logic signed [W-1:0] r, input logic signed [W-1:0] i);
        sop = s; eop = e; re = r; im = i; vld = 1'b1;
        tick();
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic idle_garbage();
        vld = 1'b0;
        sop = 1'($urandom);
        eop = 1'($urandom);
        re  = W'($urandom);
        im  = W'($urandom);
        tick();
        sop = 1'b0; eop = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle_garbage();
            send(i == 0, i == N - 1, fr_re[i], fr_im[i]);
        end
        e = model(1'b1); e.cyc = cyc + 2; q1.push_back(e);
        e = model(1'b0); e.cyc = cyc + 2; q0.push_back(e);
        n_exp++;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && (q1.size() != 0 || q0.size() != 0); k++) tick();
        tick();
        tick();
        chk("drain_q1", q1.size(), 0);
        chk("drain_q0", q0.size(), 0);
    endtask

    always @(negedge clk) begin
        if (err1) err_cnt1++;
        if (err0) err_cnt0++;
        if (reset && (err1 || err0)) chk("err_in_reset", 1, 0);
        if (sv1) begin
            n_res1++;
            res_t1.push_back(cyc);
            if (q1.size() == 0) chk("unexp_res1", 1, 0);
            else begin
                e1m = q1.pop_front();
                chk("bin1", bin1, e1m.bin);
                chk("re1", re1, e1m.re);
                chk("im1", im1, e1m.im);
                chk("mag1", mag1, e1m.mag);
                chk("lat1", cyc, e1m.cyc);
            end
        end
        if (sv0) begin
            n_res0++;
            if (q0.size() == 0) chk("unexp_res0", 1, 0);
            else begin
                e0m = q0.pop_front();
                chk("bin0", bin0, e0m.bin);
                chk("re0", re0, e0m.re);
                chk("im0", im0, e0m.im);
                chk("mag0", mag0, e0m.mag);
                chk("lat0", cyc, e0m.cyc);
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, sv1, 0);
        chk({tag, "_bin"}, bin1, 0);
        chk({tag, "_re"}, re1, 0);
        chk({tag, "_im"}, im1, 0);
        chk({tag, "_mag"}, mag1, 0);
        chk({tag, "_busy"}, busy1, 0);
        chk({tag, "_mag0"}, mag0, 0);
        chk({tag, "_busy0"}, busy0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk_outputs_zero("rst");
        chk("rst_err", err1, 0);
        reset = 1'b0;
        tick();

        // Main frame: DC dominates only when DC is searched.
        fr_re = '{100, 3, 0, -50, 0, 0, 0, 0};
        fr_im = '{0, 4, 0, 10, 0, 0, 0, 0};
        send_frame(1'b0);
        chk("busy_drain", busy1, 1);
        drain();
        chk("busy_idle", busy1, 0);
        chk("err_clean", err_cnt1, 0);

        // Tie keeps lowest index; the mirrored bin is ignored.
        fr_re = '{0, 3, 3, 0, 0, 0, 0, 127};
        fr_im = '{0, 4, 4, 0, 0, 0, 0, 127};
        send_frame(1'b0);
        drain();

        // Largest magnitude must not wrap.
        fr_re = '{0, 0, -128, 0, 0, 0, 0, 0};
        fr_im = '{0, 0, -128, 0, 0, 0, 0, 0};
        send_frame(1'b0);
        drain();

        fr_re = '{0, 0, 0, 0, 0, 0, 0, 0};
        fr_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1'b1);
        drain();

        // Short frame: eop on the 5th sample.
        send(1'b1, 1'b0, 8'sd20, 8'sd0);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 8'sd30, 8'sd1);
        send(1'b0, 1'b1, 8'sd40, 8'sd2);
        exp_err++;
        tick();
        chk("busy_after_short", busy1, 0);
        drain();
        chk("err_short", err_cnt1, exp_err);

        // sop in mid-frame restarts cleanly.
        send(1'b1, 1'b0, 8'sd90, 8'sd90);
        send(1'b0, 1'b0, 8'sd90, 8'sd90);
        send(1'b0, 1'b0, 8'sd90, 8'sd90);
        exp_err++;
        fr_re = '{100, 3, 0, -50, 0, 0, 0, 0};
        fr_im = '{0, 4, 0, 10, 0, 0, 0, 0};
        send_frame(1'b0);
        drain();
        chk("err_midsop", err_cnt1, exp_err);

        send(1'b0, 1'b0, 8'sd1, 8'sd1);
        exp_err++;
        drain();
        chk("err_idle_stray", err_cnt1, exp_err);

        // Stray sample while draining: error, but the pending result still comes out.
        fr_re = '{0, 0, 7, 0, 0, 0, 0, 0};
        fr_im = '{0, 0, -9, 0, 0, 0, 0, 0};
        send_frame(1'b0);
        send(1'b0, 1'b0, 8'sd9, 8'sd9);
        exp_err++;
        drain();
        chk("err_drain_stray", err_cnt1, exp_err);

        // Back-to-back frames with no gap.
        res_t1.delete();
        fr_re = '{0, 50, 0, 0, 0, 0, 0, 0};
        fr_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1'b0);
        fr_re = '{0, 0, 0, -60, 0, 0, 0, 0};
        fr_im = '{0, 0, 0, 5, 0, 0, 0, 0};
        send_frame(1'b0);
        drain();
        chk("b2b_n", res_t1.size(), 2);
        if (res_t1.size() == 2) chk("b2b_gap", res_t1[1] - res_t1[0], 8);

        repeat (6) begin
            for (int i = 0; i < N; i++) begin
                fr_re[i] = W'($urandom);
                fr_im[i] = W'($urandom);
            end
            send_frame(1'b1);
        end
        drain();

        // Reset mid-frame discards it; the next frame is the only result.
        send(1'b1, 1'b0, 8'sd100, 8'sd100);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 8'sd100, 8'sd100);
        reset = 1'b1;
        tick();
        tick();
        chk_outputs_zero("midrst");
        reset = 1'b0;
        tick();
        fr_re = '{5, -6, 0, 0, 0, 0, 0, 0};
        fr_im = '{0, 8, 0, 0, 0, 0, 0, 0};
        send_frame(1'b0);
        drain();

        chk("n_res1", n_res1, n_exp);
        chk("n_res0", n_res0, n_exp);
        chk("err_total1", err_cnt1, exp_err);
        chk("err_total0", err_cnt0, exp_err);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
